// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 raster constants, derived totals/sync windows, count width.
// Contents: CNT_W count width, DEF_* timing defaults, cnt_t count type, in_win() window helper.
package vga_timing_pkg;
   localparam int CNT_W         = 10;
   localparam int DEF_CLK_DIV   = 2;
   localparam int DEF_H_VISIBLE = 640;
   localparam int DEF_H_FP      = 16;
   localparam int DEF_H_SYNC    = 96;
   localparam int DEF_H_BP      = 48;
   localparam int DEF_V_VISIBLE = 480;
   localparam int DEF_V_FP      = 10;
   localparam int DEF_V_SYNC    = 2;
   localparam int DEF_V_BP      = 33;
   localparam int DEF_H_TOTAL   = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
   localparam int DEF_V_TOTAL   = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
   localparam int DEF_HS_START  = DEF_H_VISIBLE + DEF_H_FP;
   localparam int DEF_HS_END    = DEF_HS_START + DEF_H_SYNC - 1;
   localparam int DEF_VS_START  = DEF_V_VISIBLE + DEF_V_FP;
   localparam int DEF_VS_END    = DEF_VS_START + DEF_V_SYNC - 1;
   typedef logic [CNT_W-1:0] cnt_t;
   function automatic logic in_win(input int x, input int lo, input int hi);
      return (x >= lo) && (x <= hi);
   endfunction
endpackage

// File: rtl/vga_pix_tick_gen.sv
// vga_pix_tick_gen: divides clk by CLK_DIV into a one-clk pixel enable, frozen while i_en is low.
// Ports: i_clk clock, i_rst_n async active-low reset, i_en run, o_pix_tick pixel enable.
module vga_pix_tick_gen #(
   parameter int CLK_DIV = 2
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_en,
   output logic o_pix_tick
);
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   logic [DW-1:0] r_div;
   logic          r_tick;
   logic          w_wrap;
   assign w_wrap = (r_div >= DW'(CLK_DIV - 1));
   // r_tick is held (not cleared) while paused so a tick pending at the pause is
   // delivered on resume; the output gate keeps it invisible meanwhile.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_div  <= '0;
         r_tick <= 1'b0;
      end else if (i_en) begin
         r_div  <= w_wrap ? '0 : r_div + 1'b1;
         r_tick <= w_wrap;
      end
   end
   assign o_pix_tick = r_tick & i_en;
endmodule

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: VGA raster sequencer - pixel enable, h/v counters, sync/blank decode, frame strobe.
// Ports: i_clk, i_rst_n (async active-low), i_en (run); o_pix_tick, o_h_count, o_v_count,
//        o_enable_v (end of line), o_hsync/o_vsync (active low), o_video_on, o_frame_start.
// Macro VGA_TIMING_PIPE_EN: registers hsync/vsync/video_on once more on pix_tick (one-pixel lag).
module vga_timing_ctrl
   import vga_timing_pkg::*;
#(
   parameter int CLK_DIV   = DEF_CLK_DIV,
   parameter int H_VISIBLE = DEF_H_VISIBLE,
   parameter int H_FP      = DEF_H_FP,
   parameter int H_SYNC    = DEF_H_SYNC,
   parameter int H_BP      = DEF_H_BP,
   parameter int V_VISIBLE = DEF_V_VISIBLE,
   parameter int V_FP      = DEF_V_FP,
   parameter int V_SYNC    = DEF_V_SYNC,
   parameter int V_BP      = DEF_V_BP
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_en,
   output logic             o_pix_tick,
   output logic [CNT_W-1:0] o_h_count,
   output logic [CNT_W-1:0] o_v_count,
   output logic             o_enable_v,
   output logic             o_hsync,
   output logic             o_vsync,
   output logic             o_video_on,
   output logic             o_frame_start
);
   localparam int H_TOT = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam int HS_LO = H_VISIBLE + H_FP;
   localparam int HS_HI = HS_LO + H_SYNC - 1;
   localparam int VS_LO = V_VISIBLE + V_FP;
   localparam int VS_HI = VS_LO + V_SYNC - 1;
   if (H_TOT > 1024 || V_TOT > 1024) begin : g_bad_total
      $error("vga_timing_ctrl: H_TOTAL and V_TOTAL must each be <= 1024");
   end
   if (CLK_DIV < 1) begin : g_bad_div
      $error("vga_timing_ctrl: CLK_DIV must be >= 1");
   end
   logic w_tick, w_enable_v, w_hsync, w_vsync, w_video_on;
   cnt_t r_h, r_v;
   logic r_running;
   vga_pix_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_en       (i_en),
      .o_pix_tick (w_tick)
   );
   assign w_enable_v = w_tick && (r_h == cnt_t'(H_TOT - 1));
   // ">=" rather than "==" so an out-of-range count recovers to 0 on the next advance.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_h       <= '0;
         r_v       <= '0;
         r_running <= 1'b0;
      end else begin
         if (w_tick) begin
            r_running <= 1'b1;
            r_h       <= (r_h >= cnt_t'(H_TOT - 1)) ? '0 : r_h + 1'b1;
         end
         if (w_enable_v)
            r_v <= (r_v >= cnt_t'(V_TOT - 1)) ? '0 : r_v + 1'b1;
      end
   end
   assign w_hsync    = !in_win(int'(r_h), HS_LO, HS_HI);
   assign w_vsync    = !in_win(int'(r_v), VS_LO, VS_HI);
   // Including w_tick lets video_on rise on the very first tick, before r_running is set.
   assign w_video_on = (r_running || w_tick) && (int'(r_h) < H_VISIBLE) && (int'(r_v) < V_VISIBLE);
`ifdef VGA_TIMING_PIPE_EN
   logic r_hsync, r_vsync, r_video_on;
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_hsync    <= 1'b1;
         r_vsync    <= 1'b1;
         r_video_on <= 1'b0;
      end else if (w_tick) begin
         r_hsync    <= w_hsync;
         r_vsync    <= w_vsync;
         r_video_on <= w_video_on;
      end
   end
   assign o_hsync    = r_hsync;
   assign o_vsync    = r_vsync;
   assign o_video_on = r_video_on;
`else
   assign o_hsync    = w_hsync;
   assign o_vsync    = w_vsync;
   assign o_video_on = w_video_on;
`endif
   assign o_pix_tick    = w_tick;
   assign o_h_count     = r_h;
   assign o_v_count     = r_v;
   assign o_enable_v    = w_enable_v;
   assign o_frame_start = w_enable_v && (r_v == cnt_t'(V_TOT - 1));
endmodule
